// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a time on the
// SRAM-like instruction bus and hands {pc, inst, adel} to IF/ID via a valid/ready pair.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        discard;   // a committed request's data must be thrown away
    logic        misaligned;

    assign misaligned = (pc[1:0] != 2'b00);
    assign inst_req   = (state == REQ) && !misaligned;
    assign inst_addr  = pc;
    assign out_valid  = (state == HOLD);

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            discard  <= 1'b0;
            out_pc   <= 32'd0;
            out_inst <= 32'd0;
            out_adel <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= REQ;
                    if (redirect_valid) pc <= redirect_pc;
                end

                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        // Request already accepted by the bus: its data must be dropped.
                        if (inst_req && inst_addr_ok) begin
                            discard <= 1'b1;
                            state   <= WAIT;
                        end
                    end else if (misaligned) begin
                        out_pc   <= pc;
                        out_inst <= 32'd0;
                        out_adel <= 1'b1;
                        state    <= HOLD;
                    end else if (inst_addr_ok) begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (inst_data_ok) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            discard <= 1'b1;
                        end
                    end else if (inst_data_ok) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            out_pc   <= pc;
                            out_inst <= inst_rdata;
                            out_adel <= 1'b0;
                            state    <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= REQ;
                    end else if (out_ready) begin
                        pc    <= pc + PC_STEP;
                        state <= REQ;
                    end
                end

                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays the instruction-bus slave and the
// IF/ID consumer, and tracks fetches as transactions (outstanding request, held word, epoch).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_adel       (out_adel)
    );

    always #5 clk = ~clk;

    // Transaction-level model of the fetch stage.
    logic        boot_m;     // first cycle after reset: nothing issued yet
    logic [31:0] pc_m;       // architectural fetch PC
    int          epoch_m;    // bumped by every redirect
    logic        out_m;      // a bus request is outstanding
    logic [31:0] oaddr_m;
    int          oep_m;      // epoch the outstanding request was issued in
    logic        held_m;     // a word is being offered to IF/ID
    logic [31:0] mo_pc, mo_inst;
    logic        mo_adel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        boot_m  = 1'b1;
        pc_m    = RESET_PC;
        epoch_m = 0;
        out_m   = 1'b0;
        oaddr_m = 32'd0;
        oep_m   = 0;
        held_m  = 1'b0;
        mo_pc   = 32'd0;
        mo_inst = 32'd0;
        mo_adel = 1'b0;
    endtask

    function automatic logic idle_m();
        return !boot_m && !out_m && !held_m;
    endfunction

    task automatic compare();
        check("inst_req",  {31'd0, inst_req},  {31'd0, idle_m() && (pc_m[1:0] == 2'b00)});
        check("inst_addr", inst_addr,          pc_m);
        check("out_valid", {31'd0, out_valid}, {31'd0, held_m});
        check("out_pc",    out_pc,             mo_pc);
        check("out_inst",  out_inst,           mo_inst);
        check("out_adel",  {31'd0, out_adel},  {31'd0, mo_adel});
    endtask

    // Advance the model across one rising edge using the inputs the DUT saw, then compare.
    task automatic cyc();
        logic idle, was_held, was_out;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            idle     = idle_m();
            was_held = held_m;
            was_out  = out_m;
            if (was_out && inst_data_ok) begin
                out_m = 1'b0;
                if (!redirect_valid && oep_m == epoch_m) begin
                    held_m  = 1'b1;
                    mo_pc   = oaddr_m;
                    mo_inst = inst_rdata;
                    mo_adel = 1'b0;
                end
            end
            if (idle) begin
                if (pc_m[1:0] == 2'b00) begin
                    if (inst_addr_ok) begin
                        out_m   = 1'b1;
                        oaddr_m = pc_m;
                        oep_m   = epoch_m;
                    end
                end else if (!redirect_valid) begin
                    held_m  = 1'b1;
                    mo_pc   = pc_m;
                    mo_inst = 32'd0;
                    mo_adel = 1'b1;
                end
            end
            if (was_held && (redirect_valid || out_ready)) held_m = 1'b0;
            if (redirect_valid) begin
                pc_m = redirect_pc;
                epoch_m++;
            end else if (was_held && out_ready) begin
                pc_m = pc_m + 32'd4;
            end
            boot_m = 1'b0;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic aok,
                         input logic dok, input logic [31:0] rd, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_addr_ok   = aok;
        inst_data_ok   = dok;
        inst_rdata     = rd;
        out_ready      = rdy;
    endtask

    // Cooperative slave: accepts immediately, returns data one cycle later.
    task automatic run(input int n, input logic rdy);
        repeat (n) begin
            drive(1'b0, 32'd0, 1'b1, out_m, $urandom, rdy);
            cyc();
        end
    endtask

    // kind 0: until a request is outstanding; 1: until requesting; 2: until a word is held
    task automatic reach(input int kind);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            case (kind)
                0:       done = out_m;
                1:       done = idle_m() && (pc_m[1:0] == 2'b00);
                default: done = held_m;
            endcase
            if (!done) begin
                case (kind)
                    0:       drive(1'b0, 32'd0, 1'b1, 1'b0, $urandom, 1'b1);
                    1:       drive(1'b0, 32'd0, 1'b0, out_m, $urandom, 1'b1);
                    default: drive(1'b0, 32'd0, 1'b1, out_m, $urandom, 1'b0);
                endcase
                cyc();
            end
        end
        if (!done) check("reach_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst = 1'b1;

        // Back-to-back fetch with an always-ready consumer.
        run(9, 1'b1);

        // Consumer stall while a word is held.
        reach(2);
        repeat (5) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, $urandom, 1'b0);
            cyc();
        end
        run(4, 1'b1);

        // Redirect during WAIT; the late word must never be presented.
        reach(0);
        drive(1'b1, 32'h8000_1000, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc();
        repeat (2) begin
            drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
            cyc();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        cyc();
        check("after_discard_addr", inst_addr, 32'h8000_1000);
        run(6, 1'b1);

        // Redirect in the same cycle as addr_ok, then one discarded data_ok.
        reach(1);
        drive(1'b1, 32'h8000_2000, 1'b1, 1'b0, 32'd0, 1'b1);
        cyc();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
        cyc();
        run(6, 1'b1);

        // Redirect while holding with the consumer stalled.
        reach(2);
        drive(1'b1, 32'h8000_3000, 1'b0, 1'b0, 32'd0, 1'b0);
        cyc();
        run(6, 1'b1);

        // Misaligned redirect target raises adel without a bus request.
        drive(1'b1, 32'h8000_0002, 1'b0, 1'b0, 32'd0, 1'b0);
        cyc();
        repeat (4) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, $urandom, 1'b0);
            cyc();
        end
        check("adel_pc", out_pc, 32'h8000_0002);
        drive(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc();
        run(10, 1'b1);   // crosses the 32-bit wrap to 0

        // Reset while a request is outstanding, then a stray data_ok after release.
        reach(0);
        #1 rst = 1'b0;
        model_reset();
        #1 compare();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1);
        cyc();
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hBAD1_BAD1, 1'b1);
        cyc();
        run(9, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            drive(($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 2) != 0),
                  out_m ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0),
                  $urandom, ($urandom_range(0, 3) != 0));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
